// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending transaction controller.
// Timeout auto-refund is enabled by defining VEND_TIMEOUT_EN.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [1:0] COIN_5   = 2'd0;
  localparam logic [1:0] COIN_10  = 2'd1;
  localparam logic [1:0] COIN_25  = 2'd2;
  localparam logic [1:0] COIN_100 = 2'd3;

  localparam int CREDIT_MAX = 255;

  function automatic logic [7:0] coin_value(logic [1:0] code);
    case (code)
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_25: return 8'd25;
      default: return 8'd100;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: largest of 25/10/5 not above credit.
// Credit is always a multiple of 5, so 5c is the floor.
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [7:0] credit,
  output logic [1:0] coin
);

  always_comb begin
    coin = COIN_5;
    priority case (1'b1)
      (credit >= 8'd25): coin = COIN_25;
      (credit >= 8'd10): coin = COIN_10;
      default:           coin = COIN_5;
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit, vend, change over hopper.
// Define VEND_TIMEOUT_EN for auto-refund after TIMEOUT_CYCLES idle.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] item_sel,
  input  logic [7:0] item_cost,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       buy,
  input  logic       cancel,
  input  logic       change_ready,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       dispense_en,
  output logic [2:0] item_out,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic [7:0] credit,
  output logic       busy
);

  state_t     state;
  logic [7:0] dcnt;
  logic [8:0] sum;
  logic       coin_ok;
  logic [7:0] paid;
  logic [7:0] sel_in;
  logic [1:0] next_coin;
  logic       tmo_hit;

  assign sum     = {1'b0, credit} + {1'b0, coin_value(coin_type)};
  assign coin_ok = sum <= 9'(CREDIT_MAX);
  assign paid    = credit - coin_value(change_coin);
  // In CHANGE the selector looks ahead to the post-handshake credit.
  assign sel_in  = (state == CHANGE) ? paid : credit;

  vend_change_sel u_sel (
    .credit (sel_in),
    .coin   (next_coin)
  );

`ifdef VEND_TIMEOUT_EN
  logic [15:0] tmo;
  logic        coin_acc;
  logic        buy_refused;

  assign tmo_hit = (state == COLLECT) &&
                   (tmo == 16'(TIMEOUT_CYCLES - 1));
  assign coin_acc = (state == IDLE ||
                     (state == COLLECT && !cancel)) &&
                    coin_valid && coin_ok;
  assign buy_refused = (state == COLLECT) && !cancel &&
                       !coin_valid && buy &&
                       (credit < item_cost);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (state != COLLECT || coin_acc ||
                 buy_refused || tmo_hit) begin
      tmo <= '0;
    end else begin
      tmo <= tmo + 16'd1;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dcnt         <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      dispense_en  <= 1'b0;
      item_out     <= '0;
      change_valid <= 1'b0;
      change_coin  <= COIN_5;
      credit       <= '0;
      busy         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (state == COLLECT && (cancel || tmo_hit)) begin
            coin_reject  <= coin_valid;
            state        <= CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_coin  <= next_coin;
          end else if (coin_valid) begin
            if (coin_ok) begin
              credit <= sum[7:0];
              state  <= COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (state == COLLECT && buy) begin
            if (credit >= item_cost) begin
              item_out    <= item_sel;
              credit      <= credit - item_cost;
              dcnt        <= 8'(DISPENSE_CYCLES);
              dispense_en <= 1'b1;
              busy        <= 1'b1;
              state       <= DISPENSE;
            end else begin
              insufficient <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (dcnt == 8'd1) begin
            dcnt        <= '0;
            dispense_en <= 1'b0;
            if (credit != 8'd0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_coin  <= next_coin;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dcnt <= dcnt - 8'd1;
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (change_ready) begin
            credit <= paid;
            if (paid == 8'd0) begin
              change_valid <= 1'b0;
              change_coin  <= COIN_5;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              change_coin <= next_coin;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scenario bench for vend_ctrl; change coins are checked against
// a queue of expected coins filled when each refund is requested.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] item_sel;
  logic [7:0] item_cost;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       buy;
  logic       cancel;
  logic       change_ready;
  logic       coin_reject;
  logic       insufficient;
  logic       dispense_en;
  logic [2:0] item_out;
  logic       change_valid;
  logic [1:0] change_coin;
  logic [7:0] credit;
  logic       busy;

  int total  = 0;
  int passed = 0;
  int q[$];

  vend_ctrl #(
    .DISPENSE_CYCLES (4),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .item_sel     (item_sel),
    .item_cost    (item_cost),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .buy          (buy),
    .cancel       (cancel),
    .change_ready (change_ready),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .dispense_en  (dispense_en),
    .item_out     (item_out),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .credit       (credit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int cents(logic [1:0] c);
    case (c)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return 100;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n        = 1'b0;
    item_sel     = '0;
    item_cost    = '0;
    coin_valid   = 1'b0;
    coin_type    = '0;
    buy          = 1'b0;
    cancel       = 1'b0;
    change_ready = 1'b0;
    q.delete();
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick;
    coin_valid = 1'b0;
  endtask

  task automatic wait_dispense(output int n);
    n = 0;
    while (dispense_en && n < 300) begin
      n++;
      tick;
    end
  endtask

  task automatic run_change(input int start, input int stall_idx);
    int exp_credit;
    int idx;
    int guard;
    logic [1:0] exp;
    logic [1:0] hc;
    logic [7:0] hcr;
    exp_credit   = start;
    idx          = 0;
    guard        = 0;
    change_ready = 1'b0;
    while (q.size() > 0 && guard < 200) begin
      guard++;
      if (!change_valid) begin
        tick;
        continue;
      end
      exp = 2'(q.pop_front());
      if (idx == stall_idx) begin
        hc  = change_coin;
        hcr = credit;
        repeat (3) tick;
        total++;
        if ({change_valid, change_coin, credit} !== {1'b1, hc, hcr})
          $display("FAIL change_stall got v=%0b c=%0d cr=%0d want v=1 c=%0d cr=%0d",
                   change_valid, change_coin, credit, hc, hcr);
        else passed++;
      end
      total++;
      if (change_coin !== exp || credit !== 8'(exp_credit))
        $display("FAIL change_coin%0d got coin=%0d credit=%0d want coin=%0d credit=%0d",
                 idx, change_coin, credit, exp, exp_credit);
      else passed++;
      change_ready = 1'b1;
      tick;
      change_ready = 1'b0;
      exp_credit -= cents(exp);
      idx++;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL change_timeout got %0d coins left want 0", q.size());
      q.delete();
    end
    total++;
    if ({change_valid, busy, credit} !== 10'd0)
      $display("FAIL change_end got v=%0b busy=%0b credit=%0d want 0 0 0",
               change_valid, busy, credit);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    do_reset;
    total++;
    if ({coin_reject, insufficient, dispense_en, item_out, change_valid,
         change_coin, credit, busy} !== 19'd0)
      $display("FAIL reset_outputs got cr=%0d busy=%0b want all zero",
               credit, busy);
    else passed++;
  endtask

  task automatic test_exact;
    int n;
    logic saw_cv;
    do_reset;
    coin(2'd3);
    coin(2'd2);
    total++;
    if (credit !== 8'd125)
      $display("FAIL exact_credit_in got %0d want 125", credit);
    else passed++;
    item_sel  = 3'd5;
    item_cost = 8'd125;
    buy       = 1'b1;
    tick;
    buy       = 1'b0;
    item_sel  = 3'd1;
    item_cost = 8'd200;
    total++;
    if ({dispense_en, item_out, credit, busy} !== {1'b1, 3'd5, 8'd0, 1'b1})
      $display("FAIL exact_vend got en=%0b item=%0d cr=%0d busy=%0b want 1 5 0 1",
               dispense_en, item_out, credit, busy);
    else passed++;
    saw_cv = 1'b0;
    n = 0;
    while (dispense_en && n < 300) begin
      saw_cv |= change_valid;
      n++;
      tick;
    end
    total++;
    if (n !== 4)
      $display("FAIL exact_dispense_len got %0d want 4", n);
    else passed++;
    total++;
    if ({saw_cv, change_valid, busy, credit} !== 11'd0)
      $display("FAIL exact_idle got cv=%0b busy=%0b cr=%0d want 0 0 0",
               saw_cv | change_valid, busy, credit);
    else passed++;
  endtask

  task automatic test_change;
    int n;
    do_reset;
    coin(2'd3);
    coin(2'd3);
    item_sel  = 3'd2;
    item_cost = 8'd85;
    buy       = 1'b1;
    tick;
    buy = 1'b0;
    q.push_back(2);
    q.push_back(2);
    q.push_back(2);
    q.push_back(2);
    q.push_back(1);
    q.push_back(0);
    total++;
    if (credit !== 8'd115)
      $display("FAIL change_after_buy got %0d want 115", credit);
    else passed++;
    wait_dispense(n);
    total++;
    if (n !== 4)
      $display("FAIL change_dispense_len got %0d want 4", n);
    else passed++;
    run_change(115, 1);
  endtask

  task automatic test_insufficient;
    do_reset;
    coin(2'd2);
    item_cost = 8'd50;
    buy       = 1'b1;
    tick;
    buy = 1'b0;
    total++;
    if ({insufficient, dispense_en, credit} !== {1'b1, 1'b0, 8'd25})
      $display("FAIL insuf_pulse got ins=%0b en=%0b cr=%0d want 1 0 25",
               insufficient, dispense_en, credit);
    else passed++;
    tick;
    total++;
    if ({insufficient, busy, credit} !== {1'b0, 1'b0, 8'd25})
      $display("FAIL insuf_after got ins=%0b busy=%0b cr=%0d want 0 0 25",
               insufficient, busy, credit);
    else passed++;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    q.push_back(2);
    run_change(25, -1);
  endtask

  task automatic test_reject;
    int n;
    do_reset;
    coin(2'd3);
    coin(2'd3);
    coin(2'd3);
    total++;
    if ({coin_reject, credit} !== {1'b1, 8'd200})
      $display("FAIL reject_overflow got rej=%0b cr=%0d want 1 200",
               coin_reject, credit);
    else passed++;
    tick;
    total++;
    if (coin_reject !== 1'b0)
      $display("FAIL reject_one_cycle got %0b want 0", coin_reject);
    else passed++;
    item_cost = 8'd5;
    buy       = 1'b1;
    tick;
    buy = 1'b0;
    coin(2'd0);
    total++;
    if ({coin_reject, dispense_en, credit} !== {1'b1, 1'b1, 8'd195})
      $display("FAIL reject_dispense got rej=%0b en=%0b cr=%0d want 1 1 195",
               coin_reject, dispense_en, credit);
    else passed++;
    wait_dispense(n);
    repeat (7) q.push_back(2);
    q.push_back(1);
    q.push_back(1);
    run_change(195, -1);
  endtask

  task automatic test_priority;
    do_reset;
    coin(2'd2);
    coin(2'd1);
    item_cost  = 8'd10;
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_type  = 2'd0;
    buy        = 1'b1;
    tick;
    cancel     = 1'b0;
    coin_valid = 1'b0;
    buy        = 1'b0;
    total++;
    if ({coin_reject, dispense_en, insufficient, change_valid, credit} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 8'd35})
      $display("FAIL prio_cancel got rej=%0b en=%0b ins=%0b cv=%0b cr=%0d want 1 0 0 1 35",
               coin_reject, dispense_en, insufficient, change_valid, credit);
    else passed++;
    q.push_back(2);
    q.push_back(1);
    run_change(35, -1);
  endtask

  task automatic test_reset_mid_change;
    do_reset;
    coin(2'd3);
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    total++;
    if ({change_valid, busy} !== 2'b11)
      $display("FAIL rstmid_pre got cv=%0b busy=%0b want 1 1",
               change_valid, busy);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({coin_reject, insufficient, dispense_en, item_out, change_valid,
         change_coin, credit, busy} !== 19'd0)
      $display("FAIL rstmid_outputs got cv=%0b cr=%0d busy=%0b want all zero",
               change_valid, credit, busy);
    else passed++;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    do_reset;
    coin(2'd1);
    n = 0;
`ifdef VEND_TIMEOUT_EN
    while (!change_valid && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n !== 20)
      $display("FAIL timeout_latency got %0d want 20", n);
    else passed++;
`else
    repeat (40) tick;
    total++;
    if ({change_valid, credit} !== {1'b0, 8'd10})
      $display("FAIL timeout_hold got cv=%0b cr=%0d want 0 10",
               change_valid, credit);
    else passed++;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
`endif
    q.push_back(1);
    run_change(10, -1);
  endtask

  initial begin
    test_reset;
    test_exact;
    test_change;
    test_insufficient;
    test_reject;
    test_priority;
    test_reset_mid_change;
    test_timeout;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
